// File: rtl/input_pixel_packer.sv
// input_pixel_packer
//   Crops an OUT_W x OUT_H window out of a streaming RGB source, thresholds
//   each pixel's luma to one bit (1 = black) and packs 16 pixels per word
//   into frame-buffer writes. A frame is captured only after being armed
//   by enable at source pixel (0,0).
// Ports
//   clk, reset           pixel clock, synchronous active-high reset
//   valid_in, x_in, y_in active-pixel qualifier and source coordinates
//   r_in, g_in, b_in     8-bit colour components
//   enable               arm capture of the next frame
//   wr_en/wr_addr/wr_data frame-buffer write port, MSB = leftmost pixel
//   frame_done           one-cycle pulse after the last word of a frame
//   busy                 high while capturing
//   seq_err              sticky flag for a gap inside a 16-pixel word
module input_pixel_packer #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned OUT_W     = 512,
    parameter int unsigned OUT_H     = 342,
    parameter int unsigned X_OFFSET  = 144,
    parameter int unsigned Y_OFFSET  = 129,
    parameter int unsigned THRESHOLD = 128
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 valid_in,
    input  logic [$clog2(H_ACTIVE)-1:0]          x_in,
    input  logic [$clog2(V_ACTIVE)-1:0]          y_in,
    input  logic [7:0]                           r_in,
    input  logic [7:0]                           g_in,
    input  logic [7:0]                           b_in,
    input  logic                                 enable,
    output logic                                 wr_en,
    output logic [$clog2(OUT_W/16*OUT_H)-1:0]    wr_addr,
    output logic [15:0]                          wr_data,
    output logic                                 frame_done,
    output logic                                 busy,
    output logic                                 seq_err
);

    localparam int unsigned WXW    = $clog2(OUT_W);
    localparam int unsigned WYW    = $clog2(OUT_H);
    localparam int unsigned WPR    = OUT_W / 16;
    localparam int unsigned NWORDS = WPR * OUT_H;
    localparam int unsigned AW     = $clog2(NWORDS);
    localparam int unsigned LAST   = NWORDS - 1;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } state_t;

    state_t           r_state;

    // Stage 1 registers
    logic             r_s1_vld;
    logic             r_s1_bit;
    logic [WXW-1:0]   r_s1_wx;
    logic [WYW-1:0]   r_s1_wy;

    // Stage 2 accumulator and continuity tracking
    logic [15:0]      r_acc;
    logic             r_word_ok;
    logic             r_prev_vld;
    logic [WXW-1:0]   r_prev_wx;
    logic [WYW-1:0]   r_prev_wy;

    logic             r_wr_en;
    logic [AW-1:0]    r_wr_addr;
    logic [15:0]      r_wr_data;
    logic             r_frame_done;
    logic             r_seq_err;

    // Luma and pixel bit; 16-bit sum cannot overflow (max 65280)
    logic [15:0]      w_luma_sum;
    logic             w_bit;
    assign w_luma_sum = 16'd77  * {8'd0, r_in}
                      + 16'd150 * {8'd0, g_in}
                      + 16'd29  * {8'd0, b_in};
    assign w_bit      = ({8'd0, w_luma_sum[15:8]} < 16'(THRESHOLD));

    // Window membership and window-relative coordinates
    logic             w_in_win;
    logic [WXW-1:0]   w_wx;
    logic [WYW-1:0]   w_wy;
    logic             w_arm;
    assign w_in_win = valid_in
                   && (32'(x_in) >= X_OFFSET) && (32'(x_in) < X_OFFSET + OUT_W)
                   && (32'(y_in) >= Y_OFFSET) && (32'(y_in) < Y_OFFSET + OUT_H);
    assign w_wx     = WXW'(32'(x_in) - X_OFFSET);
    assign w_wy     = WYW'(32'(y_in) - Y_OFFSET);
    assign w_arm    = valid_in && enable && (x_in == '0) && (y_in == '0);

    // Stage 2 decode of the pixel held in stage 1
    logic             w_s2_restart;
    logic             w_s2_contig;
    logic             w_s2_ok;
    logic             w_s2_last;
    logic [AW-1:0]    w_s2_addr;
    logic [15:0]      w_s2_data;
    assign w_s2_restart = (r_s1_wx[3:0] == 4'd0);
    assign w_s2_last    = (r_s1_wx[3:0] == 4'hF);
    assign w_s2_contig  = r_prev_vld && (r_prev_wy == r_s1_wy)
                       && (r_prev_wx == r_s1_wx - WXW'(1));
    // A word stays writable only while every pixel follows its left neighbour
    assign w_s2_ok      = w_s2_restart || (r_word_ok && w_s2_contig);
    assign w_s2_addr    = AW'(r_s1_wy) * AW'(WPR) + AW'(r_s1_wx >> 4);
    assign w_s2_data    = {r_acc[14:0], r_s1_bit};

    // Pipeline, packer and capture control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= WAIT_FRAME;
            r_s1_vld     <= 1'b0;
            r_s1_bit     <= 1'b0;
            r_s1_wx      <= '0;
            r_s1_wy      <= '0;
            r_acc        <= '0;
            r_word_ok    <= 1'b0;
            r_prev_vld   <= 1'b0;
            r_prev_wx    <= '0;
            r_prev_wy    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            // Stage 1: only window pixels of an armed frame enter
            r_s1_vld <= (r_state == CAPTURE) && w_in_win;
            if (w_in_win) begin
                r_s1_bit <= w_bit;
                r_s1_wx  <= w_wx;
                r_s1_wy  <= w_wy;
            end

            // Stage 2: shift, check continuity, emit completed words
            if (r_s1_vld) begin
                r_acc      <= w_s2_restart ? 16'(r_s1_bit) : w_s2_data;
                r_word_ok  <= w_s2_ok;
                r_prev_vld <= 1'b1;
                r_prev_wx  <= r_s1_wx;
                r_prev_wy  <= r_s1_wy;
                if (!w_s2_restart && !w_s2_contig) begin
                    r_seq_err <= 1'b1;
                end
                if (w_s2_last && w_s2_ok) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_s2_addr;
                    r_wr_data <= w_s2_data;
                end
            end

            case (r_state)
                WAIT_FRAME: begin
                    if (w_arm) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (r_wr_en && (r_wr_addr == AW'(LAST))) begin
                        r_state      <= WAIT_FRAME;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= WAIT_FRAME;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == CAPTURE);
    assign seq_err    = r_seq_err;

endmodule
